// File: rtl/vga_draw_arbiter_pkg.sv
// Shared constants and FSM encoding for the breakout VGA draw path.
package vga_draw_arbiter_pkg;

  localparam int N_REQ    = 3;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int W_W      = 6;
  localparam int H_W      = 4;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int REQ_PADDLE = 0;
  localparam int REQ_BALL   = 1;
  localparam int REQ_BRICK  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Requester-side bus: rectangle requests in, grant/done back out.
interface vga_draw_arbiter_if #(
  parameter int N_REQ    = vga_draw_arbiter_pkg::N_REQ,
  parameter int X_W      = vga_draw_arbiter_pkg::X_W,
  parameter int Y_W      = vga_draw_arbiter_pkg::Y_W,
  parameter int W_W      = vga_draw_arbiter_pkg::W_W,
  parameter int H_W      = vga_draw_arbiter_pkg::H_W,
  parameter int COLOUR_W = vga_draw_arbiter_pkg::COLOUR_W
) ();

  logic [N_REQ-1:0]          req;
  logic [N_REQ*X_W-1:0]      req_x;
  logic [N_REQ*Y_W-1:0]      req_y;
  logic [N_REQ*W_W-1:0]      req_w;
  logic [N_REQ*H_W-1:0]      req_h;
  logic [N_REQ*COLOUR_W-1:0] req_colour;
  logic [N_REQ-1:0]          grant;
  logic [N_REQ-1:0]          done;

  modport master (
    output req, req_x, req_y, req_w, req_h, req_colour,
    input  grant, done
  );

  modport slave (
    input  req, req_x, req_y, req_w, req_h, req_colour,
    output grant, done
  );

endinterface

// File: rtl/vga_draw_arbiter_rr_arbiter.sv
// Round-robin picker: combinational winner search from ptr, plus the ptr register.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] ptr;
  int unsigned      cand;

  // First asserted request at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!any_req && req[cand]) begin
        any_req        = 1'b1;
        grant_idx      = IDX_W'(cand);
        grant_oh[cand] = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the winner on every acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (accept)
      ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates rectangle fill requests and rasters the winner onto the VGA plotter port.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int N_REQ    = vga_draw_arbiter_pkg::N_REQ,
  parameter int X_W      = vga_draw_arbiter_pkg::X_W,
  parameter int Y_W      = vga_draw_arbiter_pkg::Y_W,
  parameter int W_W      = vga_draw_arbiter_pkg::W_W,
  parameter int H_W      = vga_draw_arbiter_pkg::H_W,
  parameter int COLOUR_W = vga_draw_arbiter_pkg::COLOUR_W,
  parameter int SCREEN_W = vga_draw_arbiter_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_draw_arbiter_pkg::SCREEN_H
) (
  input  logic                clk,
  input  logic                reset,
  vga_draw_arbiter_if.slave   bus,
  output logic                busy,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [W_W-1:0]      w0;
  logic [H_W-1:0]      h0;
  logic [COLOUR_W-1:0] col;
  logic [W_W-1:0]      cx;
  logic [H_W-1:0]      cy;
  logic                scan_end;

  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             accept;
  logic [X_W-1:0]   px;
  logic [Y_W-1:0]   py;
  logic             on_screen;
  logic             last_px;

  // DONE can accept directly so a held request is served on the edge after done.
  assign accept = (state != ST_SCAN) && win_any;
  assign busy   = (state != ST_IDLE);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req),
    .accept    (accept),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .any_req   (win_any)
  );

  // Current pixel address (wrapping adds) and its visibility.
  always_comb begin
    px        = x0 + X_W'(cx);
    py        = y0 + Y_W'(cy);
    on_screen = ((X_W+1)'(px) < (X_W+1)'(SCREEN_W)) &&
                ((Y_W+1)'(py) < (Y_W+1)'(SCREEN_H));
    last_px   = (cx == w0 - W_W'(1)) && (cy == h0 - H_W'(1));
  end

  // Zero-size rectangles enter SCAN with scan_end already set, giving the same
  // done timing (edge T+1) as the general w*h+1 case without plotting anything.
  // FSM, request latches, scan counters and registered VGA/handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      x0         <= '0;
      y0         <= '0;
      w0         <= '0;
      h0         <= '0;
      col        <= '0;
      cx         <= '0;
      cy         <= '0;
      scan_end   <= 1'b0;
      bus.grant  <= '0;
      bus.done   <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.done <= '0;
          vga_plot <= 1'b0;
          if (accept) begin
            x0        <= bus.req_x[win_idx*X_W +: X_W];
            y0        <= bus.req_y[win_idx*Y_W +: Y_W];
            w0        <= bus.req_w[win_idx*W_W +: W_W];
            h0        <= bus.req_h[win_idx*H_W +: H_W];
            col       <= bus.req_colour[win_idx*COLOUR_W +: COLOUR_W];
            cx        <= '0;
            cy        <= '0;
            scan_end  <= (bus.req_w[win_idx*W_W +: W_W] == '0) ||
                         (bus.req_h[win_idx*H_W +: H_W] == '0);
            bus.grant <= win_oh;
            state     <= ST_SCAN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (scan_end) begin
            vga_plot  <= 1'b0;
            bus.done  <= bus.grant;
            bus.grant <= '0;
            state     <= ST_DONE;
          end else begin
            vga_x      <= px;
            vga_y      <= py;
            vga_colour <= col;
            vga_plot   <= on_screen;
            if (last_px) begin
              scan_end <= 1'b1;
            end else if (cx == w0 - W_W'(1)) begin
              cx <= '0;
              cy <= cy + H_W'(1);
            end else begin
              cx <= cx + W_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: table of single-rectangle draws plus
// hand-written contention, reset and request-drop sequences.
module tb_vga_draw_arbiter;

  logic clk;
  logic reset;
  logic busy;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot;

  int checks = 0;
  int errors = 0;

  vga_draw_arbiter_if bus ();

  vga_draw_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx, x, y, w, h, c;
    int plots, cyc, fx, fy, lx, ly;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [2:0] v);
    int r = -1;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_rect(input int idx, input int x, input int y,
                          input int w, input int h, input int c);
    bus.req_x[idx*9 +: 9]      = 9'(x);
    bus.req_y[idx*8 +: 8]      = 8'(y);
    bus.req_w[idx*6 +: 6]      = 6'(w);
    bus.req_h[idx*4 +: 4]      = 4'(h);
    bus.req_colour[idx*3 +: 3] = 3'(c);
  endtask

  // Single request: scan until done, checking each pixel against a raster model.
  task automatic run_rect(input int idx, input int x, input int y, input int w,
                          input int h, input int c, output int plots, output int cyc,
                          output int fx, output int fy, output int lx, output int ly,
                          output int dn, output int raster_err);
    int p, ex, ey;
    logic eplot, got_done;
    plots = 0; cyc = 0; fx = 0; fy = 0; lx = 0; ly = 0; dn = 0; raster_err = 0;
    got_done = 1'b0;
    set_rect(idx, x, y, w, h, c);
    bus.req = 3'(1 << idx);
    @(posedge clk); #1;
    check("accept_grant", int'(bus.grant), 1 << idx);
    check("accept_busy", int'(busy), 1);
    for (int k = 1; k <= 1200 && !got_done; k++) begin
      @(posedge clk); #1;
      cyc = k;
      if (bus.done != 0) begin
        got_done = 1'b1;
        dn = int'(bus.done);
        check("done_busy", int'(busy), 1);
        check("done_plot", int'(vga_plot), 0);
        check("done_grant", int'(bus.grant), 0);
        bus.req = '0;
      end else begin
        if (k > w * h) raster_err++;
        else begin
          p = k - 1;
          ex = (x + p % w) % 512;
          ey = (y + p / w) % 256;
          eplot = (ex < 320) && (ey < 240);
          if (vga_plot !== eplot || int'(bus.grant) != (1 << idx)) raster_err++;
          if (eplot && (int'(vga_x) != ex || int'(vga_y) != ey || int'(vga_colour) != c))
            raster_err++;
        end
        if (vga_plot) begin
          if (plots == 0) begin fx = int'(vga_x); fy = int'(vga_y); end
          lx = int'(vga_x); ly = int'(vga_y);
          plots++;
        end
      end
    end
    check("done_seen", int'(got_done), 1);
    bus.req = '0;
    @(posedge clk); #1;
    check("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int plots, cyc, fx, fy, lx, ly, dn, rerr;
    int order[4];
    int nd, overlap, gap_err, multi_done;
    logic prev_done, dropped, got;

    tbl[0] = '{0, 152, 220, 32, 2, 7,  64, 65, 152, 220, 183, 221};
    tbl[1] = '{1, 318, 238,  4, 4, 5,   4, 17, 318, 238, 319, 239};
    tbl[2] = '{2,  10,  10,  0, 3, 3,   0,  1,   0,   0,   0,   0};
    tbl[3] = '{2,   5,   7,  3, 1, 2,   3,  4,   5,   7,   7,   7};
    tbl[4] = '{0, 510,  10,  4, 1, 6,   2,  5,   0,  10,   1,  10};
    tbl[5] = '{1,   0,   0,  1, 1, 1,   1,  2,   0,   0,   0,   0};
    tbl[6] = '{0,  40,  50,  5, 0, 4,   0,  1,   0,   0,   0,   0};

    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0;
    bus.req_h = '0; bus.req_colour = '0;
    reset = 1'b1;
    #22 reset = 1'b0;
    #1;
    check("rst_grant", int'(bus.grant), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_xy", int'({vga_x, vga_y, vga_colour}), 0);

    for (int i = 0; i < 7; i++) begin
      run_rect(tbl[i].idx, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].c,
               plots, cyc, fx, fy, lx, ly, dn, rerr);
      check($sformatf("v%0d_plots", i), plots, tbl[i].plots);
      check($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("v%0d_done", i), dn, 1 << tbl[i].idx);
      check($sformatf("v%0d_first", i), fx * 1000 + fy, tbl[i].fx * 1000 + tbl[i].fy);
      check($sformatf("v%0d_last", i), lx * 1000 + ly, tbl[i].lx * 1000 + tbl[i].ly);
      check($sformatf("v%0d_raster", i), rerr, 0);
    end

    // Contention from a freshly reset pointer: expect 0,1,2,0 back to back.
    @(negedge clk); reset = 1'b1; #2 reset = 1'b0;
    set_rect(0, 100, 100, 2, 1, 1);
    set_rect(1, 110, 100, 3, 1, 2);
    set_rect(2, 120, 100, 1, 2, 3);
    bus.req = 3'b111;
    nd = 0; overlap = 0; gap_err = 0; multi_done = 0; prev_done = 1'b0;
    for (int k = 0; k < 200 && nd < 4; k++) begin
      @(posedge clk); #1;
      if ($countones(bus.grant) > 1) overlap++;
      if ($countones(bus.done) > 1) multi_done++;
      if (prev_done && bus.grant == 0) gap_err++;
      prev_done = (bus.done != 0);
      if (bus.done != 0) begin
        order[nd] = idx_of(bus.done);
        nd++;
        if (nd == 4) bus.req = '0;
      end
    end
    check("cont_count", nd, 4);
    check("cont_order", order[0] * 1000 + order[1] * 100 + order[2] * 10 + order[3], 120);
    check("cont_overlap", overlap + multi_done, 0);
    check("cont_backtoback", gap_err, 0);
    @(posedge clk); #1;

    // Reset at pixel 10 of a 16x8 rect owned by requester 0 (ptr would be 1).
    set_rect(0, 60, 60, 16, 8, 4);
    bus.req = 3'b001;
    @(posedge clk); #1;
    plots = 0; got = 1'b0;
    for (int k = 0; k < 50 && plots < 10; k++) begin
      @(posedge clk); #1;
      if (vga_plot) plots++;
      if (bus.done != 0) got = 1'b1;
    end
    check("rstmid_reached", plots, 10);
    check("rstmid_nodone", int'(got), 0);
    #2 reset = 1'b1;
    #1;
    check("rstmid_outs", int'({bus.grant, bus.done, busy, vga_plot}), 0);
    check("rstmid_xy", int'({vga_x, vga_y, vga_colour}), 0);
    set_rect(1, 5, 5, 2, 2, 1);
    bus.req = 3'b011;
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    check("rstmid_ptr0", int'(bus.grant), 1);
    bus.req = '0;
    @(negedge clk); reset = 1'b1; #2 reset = 1'b0;

    // Requester 1 drops req (and scribbles its inputs) after 3 plots.
    set_rect(1, 20, 30, 4, 2, 5);
    bus.req = 3'b010;
    @(posedge clk); #1;
    plots = 0; cyc = 0; dn = 0; dropped = 1'b0; got = 1'b0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(posedge clk); #1;
      if (vga_plot && vga_x >= 20 && vga_x <= 23 && vga_y >= 30 && vga_y <= 31 && vga_colour == 5)
        plots++;
      if (plots == 3 && !dropped) begin
        dropped = 1'b1;
        bus.req = '0;
        set_rect(1, 0, 0, 1, 1, 0);
      end
      if (bus.done != 0) begin got = 1'b1; dn = int'(bus.done); cyc = k; end
    end
    check("drop_plots", plots, 8);
    check("drop_done", dn, 2);
    check("drop_cycles", cyc, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
